tdc_fifo_reader: RTL and testbench

Parametrised multi-channel successor to the single-FIFO TDC read controller. It arbitrates round-robin across NUM_CH TDC result FIFOs and drives the TDC bus (address, CSN, RDN) with programmable setup, strobe and hold cycle counts. Each word is captured and presented on a valid/ready stream tagged with its channel number. It supports single-word reads on request and an auto-drain burst mode, and sits between the TDC chip pins and the measurement/ALU logic.

---
 rtl/tdc_pkg.sv | 33 +++
 rtl/tdc_rr_arbiter.sv | 30 +++
 rtl/tdc_fifo_reader.sv | 162 ++++++++++++++++
 tb/tb_tdc_fifo_reader.sv | 240 ++++++++++++++++++++++++
 4 files changed

// File: rtl/tdc_pkg.sv
// Shared types, defaults and helpers for the TDC FIFO read controller.
package tdc_pkg;

   // Read sequencer states.
   typedef enum logic [2:0] {
      IDLE,
      SETUP,
      STROBE,
      HOLD,
      PUSH,
      DONE
   } tdc_state_t;

   localparam int TDC_DATA_W = 28;
   localparam int TDC_ADDR_W = 4;

   // FIFO read addresses of the default two-channel build, channel 0 in the LSBs.
   localparam logic [7:0] TDC_CH_ADDR = {4'd9, 4'd8};

   // Ceiling log2; returns 0 for values of 0 and 1.
   function automatic int clog2(input int value);
      int result;
      int v;
      result = 0;
      v = value - 1;
      while (v > 0) begin
         result = result + 1;
         v = v >> 1;
      end
      return result;
   endfunction

endpackage

// File: rtl/tdc_rr_arbiter.sv
// Combinational round-robin pick of the first non-empty FIFO at or after rr_ptr.
module tdc_rr_arbiter
   import tdc_pkg::*;
#(
   parameter int NUM_CH = 2,
   parameter int CH_W   = 1
) (
   input  logic [NUM_CH-1:0] ef,
   input  logic [CH_W-1:0]   rr_ptr,
   output logic [CH_W-1:0]   grant,
   output logic              any_valid
);

   int idx;

   // Scan offsets from the far end down so the nearest non-empty channel wins last.
   always_comb begin
      grant     = rr_ptr;
      any_valid = 1'b0;
      idx       = 0;
      for (int i = NUM_CH - 1; i >= 0; i--) begin
         idx = (int'(rr_ptr) + i) % NUM_CH;
         if (!ef[idx]) begin
            grant     = CH_W'(idx);
            any_valid = 1'b1;
         end
      end
   end

endmodule

// File: rtl/tdc_fifo_reader.sv
// Round-robin read controller for NUM_CH TDC result FIFOs. Drives the TDC bus
// with programmable setup/strobe/hold timing and presents each captured word
// on a channel-tagged stream.
//
// Stream handshake: a word transfers on every rising edge where out_valid and
// out_ready are both high. Once raised, out_valid stays high and out_data /
// out_ch stay constant until that transfer; out_valid never depends on
// out_ready combinationally.
module tdc_fifo_reader
   import tdc_pkg::*;
#(
   parameter int DATA_W    = TDC_DATA_W,
   parameter int ADDR_W    = TDC_ADDR_W,
   parameter int NUM_CH    = 2,
   parameter logic [NUM_CH*ADDR_W-1:0] CH_ADDR = TDC_CH_ADDR,
   parameter int T_SETUP   = 1,
   parameter int T_STROBE  = 2,
   parameter int T_HOLD    = 1,
   parameter int MAX_BURST = 4,
   localparam int CH_W     = (clog2(NUM_CH) < 1) ? 1 : clog2(NUM_CH)
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              enable,
   input  logic              mode,
   input  logic              read_req,
   input  logic [NUM_CH-1:0] ef,
   input  logic [DATA_W-1:0] tdc_data_in,
   output logic [ADDR_W-1:0] tdc_addr,
   output logic              csn,
   output logic              rdn,
   output logic [DATA_W-1:0] out_data,
   output logic [CH_W-1:0]   out_ch,
   output logic              out_valid,
   input  logic              out_ready,
   output logic              done_pulse,
   output logic              empty_pulse,
   output logic              busy,
   output tdc_state_t        dbg_state
);

   localparam int T_MAX = (T_SETUP > T_STROBE) ? ((T_SETUP > T_HOLD) ? T_SETUP : T_HOLD)
                                               : ((T_STROBE > T_HOLD) ? T_STROBE : T_HOLD);
   localparam int TW    = clog2(T_MAX) + 1;
   localparam int BW    = clog2(MAX_BURST) + 1;

   tdc_state_t      state, next_state;
   logic [TW-1:0]   tcnt, tcnt_load;
   logic [BW-1:0]   burst_cnt, words_done;
   logic [CH_W-1:0] cur_ch, rr_ptr, grant;
   logic            any_valid, read_req_q, req_edge, handshake;
   logic            start_rd, empty_hit, burst_more, bus_phase;

   tdc_rr_arbiter #(
      .NUM_CH (NUM_CH),
      .CH_W   (CH_W)
   ) u_arb (
      .ef        (ef),
      .rr_ptr    (rr_ptr),
      .grant     (grant),
      .any_valid (any_valid)
   );

   assign req_edge   = read_req & ~read_req_q;
   assign handshake  = out_valid & out_ready;
   assign words_done = burst_cnt + 1'b1;
   assign burst_more = mode & enable & ~ef[cur_ch] & (words_done < BW'(MAX_BURST));
   assign bus_phase  = (state == SETUP) || (state == STROBE) || (state == HOLD);
   assign busy       = (state != IDLE);
   assign dbg_state  = state;

   // State register and phase timer; the timer reloads whenever a new state is entered.
   always_ff @(posedge clk) begin
      if (reset) begin
         state <= IDLE;
         tcnt  <= '0;
      end else begin
         state <= next_state;
         if (next_state != state)
            tcnt <= tcnt_load;
         else if (tcnt != '0)
            tcnt <= tcnt - 1'b1;
      end
   end

   // Next-state decode, read start / empty detection and phase length selection.
   always_comb begin
      next_state = state;
      start_rd   = 1'b0;
      empty_hit  = 1'b0;
      tcnt_load  = '0;
      case (state)
         IDLE: begin
            if (enable && (mode || req_edge)) begin
               if (any_valid) begin
                  next_state = SETUP;
                  start_rd   = 1'b1;
               end else if (!mode) begin
                  empty_hit = 1'b1;
               end
            end
         end
         SETUP:   if (tcnt == '0) next_state = STROBE;
         STROBE:  if (tcnt == '0) next_state = HOLD;
         HOLD:    if (tcnt == '0) next_state = PUSH;
         PUSH:    if (handshake) next_state = burst_more ? SETUP : DONE;
         DONE:    next_state = IDLE;
         default: next_state = IDLE;
      endcase
      case (next_state)
         SETUP:   tcnt_load = TW'(T_SETUP - 1);
         STROBE:  tcnt_load = TW'(T_STROBE - 1);
         HOLD:    tcnt_load = TW'(T_HOLD - 1);
         default: tcnt_load = '0;
      endcase
   end

   // Registered bus pins, capture path, stream output and arbitration bookkeeping.
   always_ff @(posedge clk) begin
      if (reset) begin
         read_req_q  <= 1'b0;
         rr_ptr      <= '0;
         cur_ch      <= '0;
         burst_cnt   <= '0;
         csn         <= 1'b1;
         rdn         <= 1'b1;
         tdc_addr    <= '0;
         out_data    <= '0;
         out_ch      <= '0;
         out_valid   <= 1'b0;
         done_pulse  <= 1'b0;
         empty_pulse <= 1'b0;
      end else begin
         read_req_q  <= read_req;
         done_pulse  <= (state == DONE);
         empty_pulse <= empty_hit;
         csn         <= ~bus_phase;
         rdn         <= ~(state == STROBE);
         if (bus_phase)
            tdc_addr <= CH_ADDR[int'(cur_ch)*ADDR_W +: ADDR_W];
         if (start_rd) begin
            cur_ch    <= grant;
            burst_cnt <= '0;
         end
         // Last strobe cycle: the word is on the bus while rdn is still low.
         if ((state == STROBE) && (tcnt == '0)) begin
            out_data <= tdc_data_in;
            out_ch   <= cur_ch;
         end
         // Raised on the first PUSH cycle, held through backpressure, dropped on transfer.
         if (state == PUSH)
            out_valid <= ~handshake;
         else
            out_valid <= 1'b0;
         if ((state == PUSH) && handshake)
            burst_cnt <= words_done;
         if (state == DONE)
            rr_ptr <= (int'(cur_ch) == NUM_CH - 1) ? '0 : cur_ch + 1'b1;
      end
   end

endmodule

// File: tb/tb_tdc_fifo_reader.sv
// Directed bench for tdc_fifo_reader: a default-parameter instance and a
// stretched-timing instance (T_SETUP=2, T_STROBE=3, T_HOLD=2) on shared inputs.
module tb_tdc_fifo_reader;
   import tdc_pkg::*;

   localparam int W = 29;

   // ---------------- clock / reset ----------------
   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic        reset, en1, en2, mode, read_req, out_ready;
   logic [1:0]  ef;
   logic [27:0] tdc_data_in;

   logic [3:0]  addr1, addr2;
   logic        csn1, rdn1, ov1, done1, empty1, busy1;
   logic        csn2, rdn2, ov2, done2, empty2, busy2;
   logic [27:0] data1, data2;
   logic [0:0]  ch1, ch2;
   tdc_state_t  st1, st2;

   tdc_fifo_reader dut1 (
      .clk(clk), .reset(reset), .enable(en1), .mode(mode), .read_req(read_req),
      .ef(ef), .tdc_data_in(tdc_data_in), .tdc_addr(addr1), .csn(csn1), .rdn(rdn1),
      .out_data(data1), .out_ch(ch1), .out_valid(ov1), .out_ready(out_ready),
      .done_pulse(done1), .empty_pulse(empty1), .busy(busy1), .dbg_state(st1)
   );

   tdc_fifo_reader #(.T_SETUP(2), .T_STROBE(3), .T_HOLD(2)) dut2 (
      .clk(clk), .reset(reset), .enable(en2), .mode(mode), .read_req(read_req),
      .ef(ef), .tdc_data_in(tdc_data_in), .tdc_addr(addr2), .csn(csn2), .rdn(rdn2),
      .out_data(data2), .out_ch(ch2), .out_valid(ov2), .out_ready(out_ready),
      .done_pulse(done2), .empty_pulse(empty2), .busy(busy2), .dbg_state(st2)
   );

   // ---------------- scoreboard state ----------------
   int n_vec = 0;
   int n_err = 0;
   logic [W-1:0] exp_q[$];
   int done_cnt  = 0;
   int rdn_falls = 0;
   logic rdn1_prev = 1'b1;

   // Passive counters of dut1 done pulses and rdn falling edges.
   always @(negedge clk) begin
      if (done1 === 1'b1) done_cnt++;
      if (rdn1_prev === 1'b1 && rdn1 === 1'b0) rdn_falls++;
      rdn1_prev = rdn1;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached, observed running expected finished");
      $fatal(1, "watchdog");
   end

   // ---------------- driver / check tasks ----------------
   task automatic tick();
      @(negedge clk);
   endtask

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_vec++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic do_reset();
      reset = 1'b1;
      tick();
      tick();
      reset = 1'b0;
   endtask

   task automatic wait_ov1(input string tag);
      int n;
      n = 0;
      while (ov1 !== 1'b1 && n < 60) begin
         tick();
         n++;
      end
      check(tag, 64'(ov1), 64'd1);
   endtask

   // Expected pin sequence of a default mode-0 read, sampled after edges 0..8.
   logic exp_csn  [9] = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1};
   logic exp_rdn  [9] = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1};
   logic exp_ov   [9] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0};
   logic exp_done [9] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
   logic exp_busy [9] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0};
   logic exp_ch   [10] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0};

   // ---------------- directed sequence ----------------
   initial begin
      int base_done, base_falls, csn_low, rdn_low, ov_seen;
      logic [27:0] cap2;

      reset = 1'b1; en1 = 1'b0; en2 = 1'b0; mode = 1'b0; read_req = 1'b0;
      out_ready = 1'b1; ef = 2'b11; tdc_data_in = '0;
      repeat (3) tick();

      // Reset state
      check("rst csn", 64'(csn1), 64'd1);
      check("rst rdn", 64'(rdn1), 64'd1);
      check("rst addr", 64'(addr1), 64'd0);
      check("rst out_data", 64'(data1), 64'd0);
      check("rst out_ch", 64'(ch1), 64'd0);
      check("rst out_valid", 64'(ov1), 64'd0);
      check("rst done", 64'(done1), 64'd0);
      check("rst empty", 64'(empty1), 64'd0);
      check("rst busy", 64'(busy1), 64'd0);
      check("rst state", 64'(st1), 64'(IDLE));
      reset = 1'b0;
      tick();

      // Single mode-0 read from channel 0
      en1 = 1'b1; ef = 2'b10; tdc_data_in = 28'h0ABCDEF; read_req = 1'b1;
      for (int k = 0; k < 9; k++) begin
         tick();
         if (k == 1) read_req = 1'b0;
         check($sformatf("m0 csn k%0d", k), 64'(csn1), 64'(exp_csn[k]));
         check($sformatf("m0 rdn k%0d", k), 64'(rdn1), 64'(exp_rdn[k]));
         check($sformatf("m0 valid k%0d", k), 64'(ov1), 64'(exp_ov[k]));
         check($sformatf("m0 done k%0d", k), 64'(done1), 64'(exp_done[k]));
         check($sformatf("m0 busy k%0d", k), 64'(busy1), 64'(exp_busy[k]));
         if (k == 1) check("m0 addr", 64'(addr1), 64'd8);
         if (k == 5) begin
            check("m0 data", 64'(data1), 64'h0ABCDEF);
            check("m0 ch", 64'(ch1), 64'd0);
         end
      end

      // Mode-0 request with every FIFO empty
      ef = 2'b11; read_req = 1'b1;
      tick();
      check("empty pulse", 64'(empty1), 64'd1);
      check("empty csn", 64'(csn1), 64'd1);
      check("empty busy", 64'(busy1), 64'd0);
      read_req = 1'b0;
      tick();
      check("empty pulse end", 64'(empty1), 64'd0);
      check("empty rdn", 64'(rdn1), 64'd1);
      tick();
      check("empty csn late", 64'(csn1), 64'd1);

      // Auto-drain bursts: ch0 x4, ch1 x4, ch0 x2
      do_reset();
      for (int i = 0; i < 10; i++) exp_q.push_back({exp_ch[i], 28'h1000000 + 28'(i)});
      base_done = done_cnt;
      tdc_data_in = 28'h1000000; ef = 2'b00; mode = 1'b1;
      for (int i = 0; i < 10; i++) begin
         wait_ov1($sformatf("burst valid %0d", i));
         check($sformatf("burst word %0d", i), 64'({ch1, data1}), 64'(exp_q.pop_front()));
         tick();
         tdc_data_in = 28'h1000000 + 28'(i + 1);
         if (i == 7) ef = 2'b10;
         if (i == 8) ef = 2'b11;
      end
      repeat (10) tick();
      check("burst done count", 64'(done_cnt - base_done), 64'd3);
      check("burst idle busy", 64'(busy1), 64'd0);
      check("burst idle valid", 64'(ov1), 64'd0);
      mode = 1'b0;

      // Backpressure: word held, bus parked, busy edges ignored
      ef = 2'b10; out_ready = 1'b0; tdc_data_in = 28'h0123456; read_req = 1'b1;
      tick();
      read_req = 1'b0;
      wait_ov1("bp valid");
      base_falls = rdn_falls;
      for (int j = 0; j < 6; j++) begin
         check($sformatf("bp valid %0d", j), 64'(ov1), 64'd1);
         check($sformatf("bp data %0d", j), 64'(data1), 64'h0123456);
         check($sformatf("bp csn %0d", j), 64'(csn1), 64'd1);
         if (j == 1) read_req = 1'b1;
         if (j == 3) read_req = 1'b0;
         tick();
      end
      check("bp no strobe", 64'(rdn_falls - base_falls), 64'd0);
      out_ready = 1'b1;
      tick();
      check("bp released", 64'(ov1), 64'd0);
      repeat (12) tick();
      check("bp no requeue", 64'(rdn_falls - base_falls), 64'd0);
      check("bp idle", 64'(busy1), 64'd0);

      // Reset during STROBE, then a clean read
      tdc_data_in = 28'h0555AAA; read_req = 1'b1;
      tick();
      read_req = 1'b0;
      tick();
      tick();
      check("mid state", 64'(st1), 64'(STROBE));
      check("mid rdn", 64'(rdn1), 64'd0);
      reset = 1'b1;
      tick();
      check("mid rst csn", 64'(csn1), 64'd1);
      check("mid rst rdn", 64'(rdn1), 64'd1);
      check("mid rst valid", 64'(ov1), 64'd0);
      check("mid rst state", 64'(st1), 64'(IDLE));
      reset = 1'b0; tdc_data_in = 28'h0777888; read_req = 1'b1;
      tick();
      read_req = 1'b0;
      wait_ov1("after rst valid");
      check("after rst data", 64'(data1), 64'h0777888);
      check("after rst ch", 64'(ch1), 64'd0);
      tick();

      // Stretched timing instance
      en1 = 1'b0; en2 = 1'b1; ef = 2'b10; tdc_data_in = 28'h00000A1; read_req = 1'b1;
      csn_low = 0; rdn_low = 0; ov_seen = 0; cap2 = '0;
      for (int k = 0; k < 13; k++) begin
         tick();
         if (k == 1) read_req = 1'b0;
         check($sformatf("t2 csn k%0d", k), 64'(csn2), (k >= 1 && k <= 7) ? 64'd0 : 64'd1);
         check($sformatf("t2 rdn k%0d", k), 64'(rdn2), (k >= 3 && k <= 5) ? 64'd0 : 64'd1);
         if (csn2 === 1'b0) csn_low++;
         if (rdn2 === 1'b0) rdn_low++;
         if (ov2 === 1'b1) begin
            ov_seen++;
            cap2 = data2;
         end
         if (k == 4) tdc_data_in = 28'h00000B2;
         if (k == 6) tdc_data_in = 28'h00000C3;
      end
      check("t2 csn cycles", 64'(csn_low), 64'd7);
      check("t2 rdn cycles", 64'(rdn_low), 64'd3);
      check("t2 words", 64'(ov_seen), 64'd1);
      check("t2 captured", 64'(cap2), 64'h00000B2);
      check("t2 dut1 idle", 64'(st1), 64'(IDLE));

      // ---------------- final report ----------------
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
